// File: rtl/fifo_sync_param.sv
// ---------------------------------------------------------------------------
// fifo_sync_param
//   Parametrised single-clock FIFO that buffers WIDTH-bit words between the
//   host-side producer and consumer of the UART/command path.
//
//   All DEPTH entries are usable. Occupancy is held in an explicit count
//   register, and every status flag is decoded from that count. There are
//   sticky overflow and underflow error flags and a synchronous flush.
//
//   Optional build macro: FIFO_FWFT_EN
//     defined   : first-word-fall-through. read_data shows the head entry
//                 combinationally while the FIFO is not empty, and is 0 while
//                 it is empty. read pops the head entry.
//     undefined : standard mode (default). read_data is registered and is
//                 updated on the edge that accepts a read.
//
// Parameters
//   DEPTH      number of entries (>= 2, need not be a power of two)
//   WIDTH      data word width
//   AFULL_TH   almost_full  when count >= AFULL_TH
//   AEMPTY_TH  almost_empty when count <= AEMPTY_TH
//
// Ports
//   clk           in   rising-edge clock
//   reset         in   asynchronous active-high reset
//   clear         in   synchronous flush (has priority over read/write)
//   write         in   push request
//   write_data    in   word to push
//   read          in   pop request
//   read_data     out  popped word (head word in FWFT mode)
//   full, empty, almost_full, almost_empty   out  occupancy flags
//   count         out  occupancy, 0..DEPTH
//   overflow      out  sticky: a write was refused because the FIFO was full
//   underflow     out  sticky: a read was refused because the FIFO was empty
// ---------------------------------------------------------------------------
module fifo_sync_param #(
   parameter int DEPTH     = 8,
   parameter int WIDTH     = 8,
   parameter int AFULL_TH  = DEPTH - 2,
   parameter int AEMPTY_TH = 2
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       clear,
   input  logic                       write,
   input  logic [WIDTH-1:0]           write_data,
   input  logic                       read,
   output logic [WIDTH-1:0]           read_data,
   output logic                       full,
   output logic                       empty,
   output logic                       almost_full,
   output logic                       almost_empty,
   output logic [$clog2(DEPTH+1)-1:0] count,
   output logic                       overflow,
   output logic                       underflow
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = $clog2(DEPTH + 1);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic             wr_acc;
   logic             rd_acc;

   // The pointers wrap explicitly, so DEPTH does not have to be a power of two.
   function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
      return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
   endfunction

   assign full         = (count == CNT_W'(DEPTH));
   assign empty        = (count == '0);
   assign almost_full  = (count >= CNT_W'(AFULL_TH));
   assign almost_empty = (count <= CNT_W'(AEMPTY_TH));

   // A full FIFO still takes a write when a pop frees a slot on the same
   // edge. An empty FIFO never takes a read, even when a write arrives on the
   // same edge.
   assign rd_acc = read & ~empty;
   assign wr_acc = write & (~full | rd_acc);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_ptr    <= '0;
         rd_ptr    <= '0;
         count     <= '0;
         overflow  <= 1'b0;
         underflow <= 1'b0;
      end else if (clear) begin
         wr_ptr    <= '0;
         rd_ptr    <= '0;
         count     <= '0;
         overflow  <= 1'b0;
         underflow <= 1'b0;
      end else begin
         if (wr_acc) wr_ptr <= next_ptr(wr_ptr);
         if (rd_acc) rd_ptr <= next_ptr(rd_ptr);
         case ({wr_acc, rd_acc})
            2'b10:   count <= count + CNT_W'(1);
            2'b01:   count <= count - CNT_W'(1);
            default: count <= count;
         endcase
         if (write & ~wr_acc) overflow  <= 1'b1;
         if (read & ~rd_acc)  underflow <= 1'b1;
      end
   end

   // The storage array has no reset.
   always_ff @(posedge clk) begin
      if (wr_acc && !clear && !reset) mem[wr_ptr] <= write_data;
   end

`ifdef FIFO_FWFT_EN
   assign read_data = empty ? '0 : mem[rd_ptr];
`else
   // read_data keeps its last value when no read is accepted and across clear.
   always_ff @(posedge clk or posedge reset) begin
      if (reset)                 read_data <= '0;
      else if (!clear && rd_acc) read_data <= mem[rd_ptr];
   end
`endif

endmodule

// File: tb/tb_fifo_sync_param.sv
// ---------------------------------------------------------------------------
// tb_fifo_sync_param
//   Testbench for fifo_sync_param with DEPTH=8, WIDTH=8 and the default
//   thresholds.
//
//   The reference model is a queue that holds the FIFO contents. The driver
//   steps the model on each cycle. Whenever the model accepts a pop, the
//   expected word goes into exp_q. A separate monitor process compares
//   read_data with that scoreboard.
// ---------------------------------------------------------------------------
module tb_fifo_sync_param;

   localparam int DEPTH = 8;
   localparam int WIDTH = 8;
   localparam int AF_TH = DEPTH - 2;
   localparam int AE_TH = 2;

   logic             clk = 1'b0;
   logic             reset = 1'b1;
   logic             clear = 1'b0;
   logic             write = 1'b0;
   logic             read = 1'b0;
   logic [WIDTH-1:0] write_data = '0;
   logic [WIDTH-1:0] read_data;
   logic             full, empty, almost_full, almost_empty, overflow, underflow;
   logic [3:0]       count;

   int total = 0;
   int bad   = 0;

   // Model state.
   logic [WIDTH-1:0] q[$];
   logic [WIDTH-1:0] exp_q[$];
   bit               m_ov = 1'b0;
   bit               m_un = 1'b0;
   bit               mon_vld = 1'b0;

   fifo_sync_param #(.DEPTH(DEPTH), .WIDTH(WIDTH)) dut (
      .clk(clk), .reset(reset), .clear(clear), .write(write),
      .write_data(write_data), .read(read), .read_data(read_data),
      .full(full), .empty(empty), .almost_full(almost_full),
      .almost_empty(almost_empty), .count(count),
      .overflow(overflow), .underflow(underflow)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic chk_status();
      int n;
      n = q.size();
      chk("count", 32'(count), 32'(n));
      chk("full", 32'(full), 32'(n == DEPTH));
      chk("empty", 32'(empty), 32'(n == 0));
      chk("almost_full", 32'(almost_full), 32'(n >= AF_TH));
      chk("almost_empty", 32'(almost_empty), 32'(n <= AE_TH));
      chk("overflow", 32'(overflow), 32'(m_ov));
      chk("underflow", 32'(underflow), 32'(m_un));
`ifdef FIFO_FWFT_EN
      chk("fwft_data", 32'(read_data), (n == 0) ? 32'd0 : 32'(q[0]));
`endif
   endtask

   // One clock cycle: drive at negedge, update the model, check after posedge.
   task automatic cycle(input bit c, input bit w, input bit r, input logic [WIDTH-1:0] d);
      int  n;
      bit  racc, wacc;
      @(negedge clk);
      clear = c; write = w; read = r; write_data = d;
      n    = q.size();
      racc = r && (n > 0) && !c;
      wacc = w && ((n < DEPTH) || racc) && !c;
      if (c) begin
         q.delete();
         m_ov = 1'b0;
         m_un = 1'b0;
      end else begin
         if (r && !racc) m_un = 1'b1;
         if (w && !wacc) m_ov = 1'b1;
         if (racc) exp_q.push_back(q.pop_front());
         if (wacc) q.push_back(d);
      end
      @(posedge clk);
      #1;
      mon_vld = racc;
      chk_status();
   endtask

   // Reset in the middle of a cycle. The outputs must clear immediately.
   task automatic mid_reset();
      #2;
      reset = 1'b1; clear = 1'b0; write = 1'b0; read = 1'b0;
      #1;
      q.delete();
      m_ov = 1'b0;
      m_un = 1'b0;
      mon_vld = 1'b0;
      chk_status();
      chk("reset_read_data", 32'(read_data), 32'd0);
      @(posedge clk);
      #2;
      reset = 1'b0;
   endtask

`ifndef FIFO_FWFT_EN
   // Monitor: in standard mode read_data must show the popped word one cycle
   // after the read, and must otherwise hold the last popped word.
   logic [WIDTH-1:0] last_exp = '0;
   initial begin
      forever begin
         @(negedge clk or posedge reset);
         if (reset) begin
            last_exp = '0;
            exp_q.delete();
         end else begin
            if (mon_vld) begin
               if (exp_q.size() == 0) chk("scoreboard_empty", 32'd1, 32'd0);
               else last_exp = exp_q.pop_front();
            end
            chk("read_data", 32'(read_data), 32'(last_exp));
         end
      end
   end
`endif

   initial begin
      int pw, pr;
      // Reset state.
      #2;
      chk_status();
      chk("reset_read_data", 32'(read_data), 32'd0);
      @(posedge clk);
      #2;
      reset = 1'b0;

      // Write 1..8 to fill the FIFO, then read 8 words back in order.
      for (int i = 1; i <= DEPTH; i++) cycle(0, 1, 0, 8'(i));
      for (int i = 0; i < DEPTH; i++) cycle(0, 0, 1, 8'h00);

      // Overflow on a 9th write, drain, then underflow on an empty read.
      for (int i = 1; i <= DEPTH; i++) cycle(0, 1, 0, 8'(i));
      cycle(0, 1, 0, 8'h99);
      for (int i = 0; i < DEPTH; i++) cycle(0, 0, 1, 8'h00);
      cycle(0, 0, 1, 8'h00);
      cycle(0, 0, 0, 8'h00);

      // Simultaneous write and read while full, wrapping the pointers 3 times.
      cycle(1, 0, 0, 8'h00);
      for (int i = 1; i <= DEPTH; i++) cycle(0, 1, 0, 8'(i));
      cycle(0, 1, 1, 8'hAA);
      for (int i = 0; i < 3 * DEPTH; i++) cycle(0, 1, 1, 8'($urandom_range(0, 255)));
      for (int i = 0; i < DEPTH; i++) cycle(0, 0, 1, 8'h00);

      // Write and read together on an empty FIFO: the read is refused.
      cycle(1, 0, 0, 8'h00);
      cycle(0, 1, 1, 8'h55);
      cycle(0, 0, 1, 8'h00);
      cycle(0, 0, 0, 8'h00);

      // Clear with a write pending while count=5 and overflow is set.
      for (int i = 1; i <= DEPTH; i++) cycle(0, 1, 0, 8'(8'h10 + i));
      cycle(0, 1, 0, 8'hEE);
      for (int i = 0; i < 3; i++) cycle(0, 0, 1, 8'h00);
      cycle(1, 1, 0, 8'h77);
      cycle(0, 0, 1, 8'h00);

      // Write burst cut by an asynchronous reset.
      for (int i = 0; i < 4; i++) cycle(0, 1, 0, 8'(8'h40 + i));
      mid_reset();
      cycle(0, 0, 1, 8'h00);

      // Random traffic. The read/write bias moves between phases so the
      // FIFO spends time near both full and empty.
      for (int ph = 0; ph < 10; ph++) begin
         pw = (ph % 2 == 0) ? 75 : 30;
         pr = (ph % 2 == 0) ? 30 : 75;
         for (int i = 0; i < 150; i++)
            cycle($urandom_range(0, 99) < 2, $urandom_range(0, 99) < pw,
                  $urandom_range(0, 99) < pr, 8'($urandom_range(0, 255)));
      end

      // Drain, and let the monitor consume the last pop.
      for (int i = 0; i < DEPTH + 2; i++) cycle(0, 0, 1, 8'h00);
      cycle(0, 0, 0, 8'h00);
      @(negedge clk);
      #1;
      chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
